// File: rtl/tnn_popcount_pkg.sv
// Shared types and constants for the ternary-neuron popcount sequencer.
// The sequencer's build option TNN_PC_PIPE_EN (registered popcount) is handled in tnn_popcount_seq.sv.
package tnn_popcount_pkg;

  localparam int IN_W      = 21;
  localparam int PC_W      = 5;
  localparam int MAX_BEATS = 16;
  localparam int ACC_W     = 11;
  localparam int CNT_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POS,
    S_NEG,
    S_DRAIN,
    S_OUT
  } state_t;

  // Popcount results are unsigned; widen before entering the signed accumulator.
  function automatic logic [ACC_W-1:0] zext_pc(input logic [PC_W-1:0] pc);
    return {{(ACC_W-PC_W){1'b0}}, pc};
  endfunction

endpackage

// File: rtl/popcount21_core.sv
// Exact 21-input popcount. Approximate variants with the same ports drop in here.
module popcount21_core (
  input  logic [20:0] input_a,
  output logic [4:0]  out
);

  // Count the ones of the input vector.
  always_comb begin
    out = '0;
    for (int i = 0; i < 21; i++) begin
      out = out + {4'b0000, input_a[i]};
    end
  end

endmodule

// File: rtl/tnn_popcount_seq.sv
// Ternary neuron sequencer: one shared popcount unit, time-shared between
// the +1 and -1 masks of each beat, accumulating a signed sum per frame.
// Build option: define TNN_PC_PIPE_EN to register the popcount output,
// which adds an S_DRAIN step per beat (4 cycles/beat instead of 3).
//
//  state   | meaning
//  S_IDLE  | ready for a beat; first beat of a frame samples thr
//  S_POS   | popcount of +1 mask
//  S_NEG   | popcount of -1 mask (pipelined: also adds pos count)
//  S_DRAIN | pipelined only: subtract neg count, decide frame end
//  S_OUT   | result presented until out_ready handshake
module tnn_popcount_seq
  import tnn_popcount_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IN_W-1:0]  i_in_pos,
  input  logic [IN_W-1:0]  i_in_neg,
  input  logic             i_in_last,
  input  logic [ACC_W-1:0] i_thr,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_act,
  output logic [ACC_W-1:0] o_out_sum,
  output logic             o_out_trunc
);

  state_t            r_state;
  logic [IN_W-1:0]   r_pos;
  logic [IN_W-1:0]   r_neg;
  logic              r_last;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_thr;
  logic [CNT_W-1:0]  r_beat_cnt;

  logic [IN_W-1:0]   w_pc_in;
  logic [PC_W-1:0]   w_pc;
  logic              w_end_frame;

  // Single popcount instance; the neg mask is only ever needed in S_NEG.
  assign w_pc_in     = (r_state == S_NEG) ? r_neg : r_pos;
  assign w_end_frame = r_last || (r_beat_cnt == CNT_W'(MAX_BEATS - 1));

  popcount21_core u_popcount (
    .input_a (w_pc_in),
    .out     (w_pc)
  );

`ifdef TNN_PC_PIPE_EN
  logic [PC_W-1:0] r_pc;

  // Register the popcount result; consumed one state later.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_pc <= '0;
    else       r_pc <= w_pc;
  end
`endif

  // Frame sequencing FSM with registered handshake and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_pos       <= '0;
      r_neg       <= '0;
      r_last      <= 1'b0;
      r_acc       <= '0;
      r_thr       <= '0;
      r_beat_cnt  <= '0;
      o_in_ready  <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_act   <= 1'b0;
      o_out_sum   <= '0;
      o_out_trunc <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (o_in_ready && i_in_valid) begin
            r_pos      <= i_in_pos;
            r_neg      <= i_in_neg;
            r_last     <= i_in_last;
            if (r_beat_cnt == '0) r_thr <= i_thr;
            o_in_ready <= 1'b0;
            r_state    <= S_POS;
          end else begin
            o_in_ready <= 1'b1;
          end
        end
        S_POS: begin
`ifndef TNN_PC_PIPE_EN
          r_acc <= r_acc + zext_pc(w_pc);
`endif
          r_state <= S_NEG;
        end
        S_NEG: begin
`ifdef TNN_PC_PIPE_EN
          r_acc   <= r_acc + zext_pc(r_pc);
          r_state <= S_DRAIN;
`else
          r_acc      <= r_acc - zext_pc(w_pc);
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          if (w_end_frame) begin
            o_out_trunc <= ~r_last;
            r_state     <= S_OUT;
          end else begin
            o_in_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
`endif
        end
        S_DRAIN: begin
`ifdef TNN_PC_PIPE_EN
          r_acc      <= r_acc - zext_pc(r_pc);
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          if (w_end_frame) begin
            o_out_trunc <= ~r_last;
            r_state     <= S_OUT;
          end else begin
            o_in_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
`else
          r_state <= S_IDLE;
`endif
        end
        S_OUT: begin
          if (!o_out_valid) begin
            o_out_valid <= 1'b1;
            o_out_sum   <= r_acc;
            o_out_act   <= ($signed(r_acc) >= $signed(r_thr));
          end else if (i_out_ready) begin
            o_out_valid <= 1'b0;
            o_out_trunc <= 1'b0;
            r_acc       <= '0;
            r_beat_cnt  <= '0;
            o_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_popcount_seq.sv
// Self-checking bench for tnn_popcount_seq: directed table, multi-cycle
// corner sequences and a randomized run against a frame-level model.
module tb_tnn_popcount_seq;

`ifdef TNN_PC_PIPE_EN
  localparam int LAT  = 4;
  localparam int BEAT = 4;
`else
  localparam int LAT  = 3;
  localparam int BEAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [20:0] in_pos = '0;
  logic [20:0] in_neg = '0;
  logic        in_last = 1'b0;
  logic [10:0] thr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_act;
  logic [10:0] out_sum;
  logic        out_trunc;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  tnn_popcount_seq dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_pos    (in_pos),
    .i_in_neg    (in_neg),
    .i_in_last   (in_last),
    .i_thr       (thr),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_act   (out_act),
    .o_out_sum   (out_sum),
    .o_out_trunc (out_trunc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Present one beat and wait for it to be accepted; returns at the negedge after the accept edge.
  task automatic send_beat(input logic [20:0] p, input logic [20:0] n, input logic last,
                           input logic signed [10:0] t, output int acc_cyc);
    int k;
    in_pos = p; in_neg = n; in_last = last; thr = t; in_valid = 1'b1;
    for (k = 0; k < 300; k++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    if (k == 300) chk("in_ready timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  // Wait for out_valid and capture the result; handshakes if out_ready is high.
  task automatic get_result(output logic signed [10:0] s, output logic a, output logic tr,
                            output int vcyc);
    int k;
    for (k = 0; k < 300; k++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    if (k == 300) chk("out_valid timeout", 0, 1);
    s = out_sum; a = out_act; tr = out_trunc; vcyc = cyc;
    if (out_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  typedef struct {
    int                 n;
    logic [20:0]        pos [4];
    logic [20:0]        neg [4];
    logic signed [10:0] thr;
    int                 exp_sum;
    logic               exp_act;
    logic               exp_trunc;
  } vec_t;

  vec_t vecs [6];

  task automatic set_vec(input int i, input int n,
                         input logic [20:0] p0, input logic [20:0] p1, input logic [20:0] p2, input logic [20:0] p3,
                         input logic [20:0] n0, input logic [20:0] n1, input logic [20:0] n2, input logic [20:0] n3,
                         input int t, input int s, input logic a);
    vecs[i].n = n;
    vecs[i].pos[0] = p0; vecs[i].pos[1] = p1; vecs[i].pos[2] = p2; vecs[i].pos[3] = p3;
    vecs[i].neg[0] = n0; vecs[i].neg[1] = n1; vecs[i].neg[2] = n2; vecs[i].neg[3] = n3;
    vecs[i].thr = 11'(t);
    vecs[i].exp_sum = s;
    vecs[i].exp_act = a;
    vecs[i].exp_trunc = 1'b0;
  endtask

  typedef struct {
    logic [20:0]        pos;
    logic [20:0]        neg;
    logic               last;
    logic signed [10:0] thr;
  } beat_t;

  typedef struct {
    int   sum;
    logic act;
    logic trunc;
  } res_t;

  beat_t beats[$];
  res_t  exp_q[$];

  initial begin
    logic signed [10:0] s, s0;
    logic a, tr, a0;
    int ac, ac1, vc, k;
    bit stable;

    set_vec(0, 1, 21'h1FFFFF, 0, 0, 0, 0, 0, 0, 0, 21, 21, 1'b1);
    set_vec(1, 2, 21'h7, 21'h0, 0, 0, 21'h0, 21'h1F, 0, 0, 0, -2, 1'b0);
    set_vec(2, 1, 0, 0, 0, 0, 21'h1FFFFF, 0, 0, 0, -21, -21, 1'b1);
    set_vec(3, 1, 0, 0, 0, 0, 21'h1FFFFF, 0, 0, 0, -20, -21, 1'b0);
    set_vec(4, 3, 21'hFF, 21'hF, 21'h3, 0, 21'h1, 21'h1, 21'h1, 0, 12, 11, 1'b0);
    set_vec(5, 4, 21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF, 0, 0, 0, 0, 84, 84, 1'b1);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_sum", int'(out_sum), 0);
    chk("reset out_act", int'(out_act), 0);
    chk("reset out_trunc", int'(out_trunc), 0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < vecs[i].n; b++)
        send_beat(vecs[i].pos[b], vecs[i].neg[b], logic'(b == vecs[i].n - 1), vecs[i].thr, ac);
      get_result(s, a, tr, vc);
      chk($sformatf("vec%0d sum", i), int'(s), vecs[i].exp_sum);
      chk($sformatf("vec%0d act", i), int'(a), int'(vecs[i].exp_act));
      chk($sformatf("vec%0d trunc", i), int'(tr), int'(vecs[i].exp_trunc));
      if (i == 0) chk("latency", vc - ac, LAT);
    end

    // Truncation at MAX_BEATS, then the extra beat opens a new frame with a new threshold
    for (int b = 0; b < 16; b++) begin
      send_beat(21'h1, 21'h0, 1'b0, 11'sd0, ac);
      if (b == 0) ac1 = ac;
      if (b == 1) chk("beat spacing", ac - ac1, BEAT);
    end
    get_result(s, a, tr, vc);
    chk("trunc sum", int'(s), 16);
    chk("trunc flag", int'(tr), 1);
    chk("trunc act", int'(a), 1);
    send_beat(21'h1, 21'h0, 1'b1, 11'sd2, ac);
    get_result(s, a, tr, vc);
    chk("after trunc sum", int'(s), 1);
    chk("after trunc act", int'(a), 0);
    chk("after trunc flag", int'(tr), 0);

    // Backpressure: result held stable, no beats accepted
    out_ready = 1'b0;
    send_beat(21'h3F, 21'h1, 1'b1, 11'sd10, ac);
    get_result(s0, a0, tr, vc);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!out_valid || out_sum != s0 || out_act != a0 || in_ready) stable = 1'b0;
    end
    chk("stall stable", int'(stable), 1);
    chk("stall sum", int'(s0), 5);
    chk("stall act", int'(a0), 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("release in_ready", int'(in_ready), 1);
    chk("release out_valid", int'(out_valid), 0);

    // Reset in the middle of the second beat's S_NEG
    send_beat(21'h7, 21'h0, 1'b0, 11'sd0, ac);
    send_beat(21'h7, 21'h0, 1'b0, 11'sd0, ac);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst in_ready", int'(in_ready), 0);
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst out_sum", int'(out_sum), 0);
    chk("midrst out_act", int'(out_act), 0);
    chk("midrst out_trunc", int'(out_trunc), 0);
    rst = 1'b0;
    send_beat(21'h3, 21'h0, 1'b1, 11'sd0, ac);
    get_result(s, a, tr, vc);
    chk("post rst sum", int'(s), 2);
    chk("post rst trunc", int'(tr), 0);

    // Randomized frames against a frame-level model
    for (int f = 0; f < 25; f++) begin
      int len = int'($urandom_range(20, 1));
      for (int b = 0; b < len; b++) begin
        beat_t bt;
        bt.pos  = 21'($urandom);
        bt.neg  = 21'($urandom);
        if ($urandom_range(3) == 0) bt.pos = 21'h1FFFFF;
        bt.last = logic'(b == len - 1);
        bt.thr  = 11'(int'($urandom_range(200)) - 100);
        beats.push_back(bt);
      end
    end
    begin
      int sum = 0, cnt = 0;
      logic signed [10:0] th = '0;
      foreach (beats[j]) begin
        res_t r;
        if (cnt == 0) th = beats[j].thr;
        sum += $countones(beats[j].pos) - $countones(beats[j].neg);
        cnt++;
        if (beats[j].last || cnt == 16) begin
          r.sum = sum; r.act = logic'(sum >= int'(th)); r.trunc = ~beats[j].last;
          exp_q.push_back(r);
          sum = 0; cnt = 0;
        end
      end
    end
    fork
      begin
        foreach (beats[j]) send_beat(beats[j].pos, beats[j].neg, beats[j].last, beats[j].thr, ac);
      end
      begin
        int got = 0, guard = 0;
        logic signed [10:0] rs;
        while (got < exp_q.size() && guard < 20000) begin
          @(negedge clk);
          guard++;
          out_ready = logic'($urandom_range(1));
          if (out_valid && out_ready) begin
            rs = out_sum;
            chk($sformatf("rand%0d sum", got), int'(rs), exp_q[got].sum);
            chk($sformatf("rand%0d act", got), int'(out_act), int'(exp_q[got].act));
            chk($sformatf("rand%0d trunc", got), int'(out_trunc), int'(exp_q[got].trunc));
            got++;
          end
        end
        if (got < exp_q.size()) chk("rand result timeout", got, exp_q.size());
        out_ready = 1'b1;
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
